coin_acceptor: RTL and testbench

- Payment front-end upstream of the washing machine FSM.
- Debounces the raw coin-mechanism switch and accumulates credit against the price of the selected mode.
- Drives the washer's active-low coin input once payment is sufficient.
- Deducts the price when a wash cycle starts, and dispenses refund/change coins one pulse at a time on cancel or cycle completion.

---
 rtl/coin_pkg.sv | 22 ++
 rtl/coin_debounce.sv | 56 +++++
 rtl/coin_acceptor.sv | 227 ++++++++++++++++++++++
 tb/tb_coin_acceptor.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared types and default constants for the coin acceptor front-end.
package coin_pkg;

    localparam int CREDIT_W_DEF = 4;
    localparam int PRICE_M1_DEF = 2;
    localparam int PRICE_M2_DEF = 3;
    localparam int PRICE_M3_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_PAID    = 3'd2,
        ST_IN_USE  = 3'd3,
        ST_REFUND  = 3'd4
    } coin_state_e;

    typedef enum logic {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } refund_phase_e;

endpackage

// File: rtl/coin_debounce.sv
// Two-flop synchroniser followed by a stable-count filter.
// Emits a one-cycle pulse when the filtered level rises.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             pulse_r;
    logic [CNT_W-1:0] cnt_r;

    // Bring the asynchronous input into the clock domain
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= i_in;
            sync2_r <= sync1_r;
        end
    end

    // Flip the filtered level only after DEBOUNCE_CYCLES consistent samples
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            level_r <= 1'b0;
            cnt_r   <= '0;
            pulse_r <= 1'b0;
        end else begin
            pulse_r <= 1'b0;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    cnt_r   <= '0;
                    pulse_r <= sync2_r;
                end else begin
                    cnt_r <= cnt_r + 1'b1;
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign o_pulse = pulse_r;

endmodule

// File: rtl/coin_acceptor.sv
// Payment front-end: counts debounced coins against the selected mode's
// price, signals "paid" to the washer, deducts at cycle start and returns
// remaining credit as timed solenoid pulses.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PRICE_M1        = PRICE_M1_DEF,
    parameter int PRICE_M2        = PRICE_M2_DEF,
    parameter int PRICE_M3        = PRICE_M3_DEF,
    parameter int CREDIT_W        = CREDIT_W_DEF,
    parameter int REFUND_ON       = 25000,
    parameter int REFUND_OFF      = 25000
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_coin_raw,
    input  logic                i_mode_1,
    input  logic                i_mode_2,
    input  logic                i_mode_3,
    input  logic                i_cancel,
    input  logic                i_cycle_active,
    input  logic                i_cycle_done,
    output logic                o_coin_n,
    output logic [CREDIT_W-1:0] o_credit,
    output logic [CREDIT_W-1:0] o_price,
    output logic                o_refund,
    output logic                o_refund_busy,
    output logic                o_reject
);

    localparam int RT_MAX = (REFUND_ON > REFUND_OFF) ? REFUND_ON : REFUND_OFF;
    localparam int RT_W   = (RT_MAX > 1) ? $clog2(RT_MAX) : 1;
    localparam logic [RT_W-1:0]     ON_LAST    = RT_W'(REFUND_ON - 1);
    localparam logic [RT_W-1:0]     OFF_LAST   = RT_W'(REFUND_OFF - 1);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;
    localparam logic [CREDIT_W-1:0] CREDIT_ONE = CREDIT_W'(1);

    coin_state_e         state_r, state_nxt_s;
    refund_phase_e       phase_r, phase_nxt_s;
    logic [CREDIT_W-1:0] credit_r, credit_nxt_s, credit_inc_s, price_s;
    logic [RT_W-1:0]     rtimer_r, rtimer_nxt_s;
    logic                coin_pulse_s, cyc_act_d_r, cyc_rise_s;
    logic                accept_s, reject_s;
    logic                coin_n_r, refund_r, busy_r, reject_r;
    logic [CREDIT_W-1:0] price_r;

    // Price must be non-zero and covered by the credit
    function automatic logic sufficient(input logic [CREDIT_W-1:0] credit,
                                        input logic [CREDIT_W-1:0] price);
        return (price != '0) && (credit >= price);
    endfunction

    coin_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_coin_debounce (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_in   (i_coin_raw),
        .o_pulse(coin_pulse_s)
    );

    assign cyc_rise_s   = i_cycle_active & ~cyc_act_d_r;
    assign credit_inc_s = credit_r + {{(CREDIT_W-1){1'b0}}, accept_s};

    // Price of the selected mode, mode 1 has highest priority
    always_comb begin
        price_s = '0;
        if (i_mode_1) begin
            price_s = CREDIT_W'(PRICE_M1);
        end else if (i_mode_2) begin
            price_s = CREDIT_W'(PRICE_M2);
        end else if (i_mode_3) begin
            price_s = CREDIT_W'(PRICE_M3);
        end else begin
            price_s = '0;
        end
    end

    // Coins are refused while busy with a wash or refund, or when credit is full
    always_comb begin
        accept_s = 1'b0;
        reject_s = 1'b0;
        if (coin_pulse_s) begin
            if ((state_r == ST_IN_USE) || (state_r == ST_REFUND) ||
                (credit_r == CREDIT_MAX)) begin
                reject_s = 1'b1;
            end else begin
                accept_s = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
            reject_s = 1'b0;
        end
    end

    // Next-state, credit and refund timer; sufficiency looks at the credit
    // including this cycle's coin so "paid" follows the coin immediately
    always_comb begin
        state_nxt_s  = state_r;
        credit_nxt_s = credit_inc_s;
        phase_nxt_s  = phase_r;
        rtimer_nxt_s = rtimer_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_COLLECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (i_cancel) begin
                    state_nxt_s  = ST_REFUND;
                    phase_nxt_s  = PH_ON;
                    rtimer_nxt_s = '0;
                end else if (sufficient(credit_inc_s, price_s)) begin
                    state_nxt_s = ST_PAID;
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end
            ST_PAID: begin
                if (i_cancel) begin
                    state_nxt_s  = ST_REFUND;
                    phase_nxt_s  = PH_ON;
                    rtimer_nxt_s = '0;
                end else if (!sufficient(credit_inc_s, price_s)) begin
                    state_nxt_s = ST_COLLECT;
                end else if (cyc_rise_s) begin
                    state_nxt_s  = ST_IN_USE;
                    credit_nxt_s = credit_inc_s - price_s;
                end else begin
                    state_nxt_s = ST_PAID;
                end
            end
            ST_IN_USE: begin
                credit_nxt_s = credit_r;
                if (i_cycle_done) begin
                    if (credit_r != '0) begin
                        state_nxt_s  = ST_REFUND;
                        phase_nxt_s  = PH_ON;
                        rtimer_nxt_s = '0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IN_USE;
                end
            end
            ST_REFUND: begin
                credit_nxt_s = credit_r;
                if (credit_r == '0) begin
                    state_nxt_s = ST_IDLE;
                end else if (phase_r == PH_ON) begin
                    if (rtimer_r == ON_LAST) begin
                        phase_nxt_s  = PH_OFF;
                        rtimer_nxt_s = '0;
                    end else begin
                        rtimer_nxt_s = rtimer_r + 1'b1;
                    end
                end else begin
                    if (rtimer_r == OFF_LAST) begin
                        credit_nxt_s = credit_r - 1'b1;
                        phase_nxt_s  = PH_ON;
                        rtimer_nxt_s = '0;
                        if (credit_r == CREDIT_ONE) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_REFUND;
                        end
                    end else begin
                        rtimer_nxt_s = rtimer_r + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                credit_nxt_s = '0;
                phase_nxt_s  = PH_ON;
                rtimer_nxt_s = '0;
            end
        endcase
    end

    // State, credit, refund timer and cycle_active edge history
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            credit_r    <= '0;
            phase_r     <= PH_ON;
            rtimer_r    <= '0;
            cyc_act_d_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            credit_r    <= credit_nxt_s;
            phase_r     <= phase_nxt_s;
            rtimer_r    <= rtimer_nxt_s;
            cyc_act_d_r <= i_cycle_active;
        end
    end

    // Output registers; coin_n trails the state by one cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            coin_n_r <= 1'b1;
            refund_r <= 1'b0;
            busy_r   <= 1'b0;
            reject_r <= 1'b0;
            price_r  <= '0;
        end else begin
            coin_n_r <= (state_r != ST_PAID);
            refund_r <= (state_nxt_s == ST_REFUND) && (phase_nxt_s == PH_ON);
            busy_r   <= (state_nxt_s == ST_REFUND);
            reject_r <= reject_s;
            price_r  <= price_s;
        end
    end

    assign o_coin_n      = coin_n_r;
    assign o_credit      = credit_r;
    assign o_price       = price_r;
    assign o_refund      = refund_r;
    assign o_refund_busy = busy_r;
    assign o_reject      = reject_r;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: table-driven price/paid vectors, a credit
// scoreboard fed by the stimulus, and hand sequences for timing corners.
module tb_coin_acceptor;

    logic       i_clk;
    logic       i_rst;
    logic       i_coin_raw;
    logic       i_mode_1, i_mode_2, i_mode_3;
    logic       i_cancel;
    logic       i_cycle_active;
    logic       i_cycle_done;
    logic       o_coin_n;
    logic [3:0] o_credit;
    logic [3:0] o_price;
    logic       o_refund;
    logic       o_refund_busy;
    logic       o_reject;

    coin_acceptor #(
        .DEBOUNCE_CYCLES(4),
        .PRICE_M1(2),
        .PRICE_M2(3),
        .PRICE_M3(4),
        .CREDIT_W(4),
        .REFUND_ON(3),
        .REFUND_OFF(3)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_coin_raw    (i_coin_raw),
        .i_mode_1      (i_mode_1),
        .i_mode_2      (i_mode_2),
        .i_mode_3      (i_mode_3),
        .i_cancel      (i_cancel),
        .i_cycle_active(i_cycle_active),
        .i_cycle_done  (i_cycle_done),
        .o_coin_n      (o_coin_n),
        .o_credit      (o_credit),
        .o_price       (o_price),
        .o_refund      (o_refund),
        .o_refund_busy (o_refund_busy),
        .o_reject      (o_reject)
    );

    typedef struct {
        logic m1;
        logic m2;
        logic m3;
        int   coins;
        int   exp_price;
        int   exp_coin_n;
        int   exp_credit;
    } vec_t;

    vec_t vecs[9];
    int   checks;
    int   errors;
    int   exp_q[$];
    bit   sb_en;
    int   last_credit;
    int   rej_seen, ref_hi, busy_cnt, ref_rises;
    bit   ref_prev;

    // Free-running clock
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock; samples 1 time unit after the edge and runs the scoreboard
    task automatic tick();
        int e;
        @(posedge i_clk);
        #1;
        if (o_reject) rej_seen++;
        if (o_refund) ref_hi++;
        if (o_refund_busy) busy_cnt++;
        if (o_refund && !ref_prev) ref_rises++;
        ref_prev = o_refund;
        if (sb_en && (int'(o_credit) != last_credit)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL credit_unexpected: got %0d expected no change from %0d",
                         o_credit, last_credit);
            end else begin
                e = exp_q.pop_front();
                check("credit_sb", int'(o_credit), e);
            end
        end
        last_credit = int'(o_credit);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        rej_seen  = 0;
        ref_hi    = 0;
        busy_cnt  = 0;
        ref_rises = 0;
    endtask

    task automatic do_reset();
        sb_en          = 1'b0;
        i_rst          = 1'b1;
        i_coin_raw     = 1'b0;
        i_mode_1       = 1'b0;
        i_mode_2       = 1'b0;
        i_mode_3       = 1'b0;
        i_cancel       = 1'b0;
        i_cycle_active = 1'b0;
        i_cycle_done   = 1'b0;
        ticks(2);
        i_rst = 1'b0;
        tick();
        sb_en = 1'b1;
        clear_counts();
    endtask

    // Clean coin: long enough high to count, long enough low to re-arm
    task automatic insert_coin(input int exp_after);
        if (exp_after >= 0) exp_q.push_back(exp_after);
        i_coin_raw = 1'b1;
        ticks(10);
        i_coin_raw = 1'b0;
        ticks(8);
    endtask

    task automatic glitch(input logic v, input int n);
        i_coin_raw = v;
        ticks(n);
    endtask

    initial begin
        int lat;
        checks      = 0;
        errors      = 0;
        last_credit = 0;
        ref_prev    = 1'b0;
        vecs[0] = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 2, 2, 0, 2};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 3, 3, 0, 3};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 2, 3, 1, 2};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 4, 4, 0, 4};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 3, 4, 1, 3};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 2, 2, 0, 2};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 3, 3, 0, 3};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 5, 0, 1, 5};

        // Reset state
        do_reset();
        check("rst_credit", int'(o_credit), 0);
        check("rst_coin_n", int'(o_coin_n), 1);
        check("rst_refund", int'(o_refund), 0);
        check("rst_busy", int'(o_refund_busy), 0);
        check("rst_reject", int'(o_reject), 0);
        check("rst_price", int'(o_price), 0);

        // Bouncy coin: glitches are filtered, stable rise counted after 7 cycles
        glitch(1'b1, 1); glitch(1'b0, 3);
        glitch(1'b1, 2); glitch(1'b0, 3);
        glitch(1'b1, 1); glitch(1'b0, 5);
        check("bounce_no_count", int'(o_credit), 0);
        exp_q.push_back(1);
        i_coin_raw = 1'b1;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if ((o_credit == 4'd1) && (lat == 0)) lat = i;
        end
        i_coin_raw = 1'b0;
        ticks(8);
        check("bounce_latency", lat, 7);
        check("bounce_credit", int'(o_credit), 1);
        check("bounce_reject", rej_seen, 0);

        // Table: price selection and paid indication
        for (int v = 0; v < 9; v++) begin
            do_reset();
            i_mode_1 = vecs[v].m1;
            i_mode_2 = vecs[v].m2;
            i_mode_3 = vecs[v].m3;
            for (int c = 1; c <= vecs[v].coins; c++) insert_coin(c);
            ticks(3);
            check($sformatf("vec%0d_price", v), int'(o_price), vecs[v].exp_price);
            check($sformatf("vec%0d_coin_n", v), int'(o_coin_n), vecs[v].exp_coin_n);
            check($sformatf("vec%0d_credit", v), int'(o_credit), vecs[v].exp_credit);
        end

        // Mode 2: o_coin_n falls one cycle after credit reaches the price
        do_reset();
        i_mode_2 = 1'b1;
        insert_coin(1);
        insert_coin(2);
        exp_q.push_back(3);
        i_coin_raw = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if ((o_credit == 4'd3) && (lat == 0)) begin
                lat = i;
                check("paid_coin_n_before", int'(o_coin_n), 1);
                tick();
                check("paid_coin_n_after", int'(o_coin_n), 0);
            end
        end
        check("paid_credit_reached", int'(lat != 0), 1);
        i_coin_raw = 1'b0;
        ticks(8);

        // Mode 1: deduct at cycle start, reject in use, refund change on done
        do_reset();
        i_mode_1 = 1'b1;
        insert_coin(1);
        insert_coin(2);
        insert_coin(3);
        check("use_paid", int'(o_coin_n), 0);
        exp_q.push_back(1);
        i_cycle_active = 1'b1;
        ticks(2);
        check("use_credit", int'(o_credit), 1);
        check("use_coin_n", int'(o_coin_n), 1);
        i_cancel = 1'b1;
        ticks(2);
        i_cancel = 1'b0;
        check("use_cancel_ignored", int'(o_refund_busy), 0);
        clear_counts();
        insert_coin(-1);
        check("use_reject", rej_seen, 1);
        check("use_reject_credit", int'(o_credit), 1);
        i_cycle_active = 1'b0;
        i_cycle_done   = 1'b1;
        exp_q.push_back(0);
        clear_counts();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) i_cycle_done = 1'b0;
        end
        check("done_ref_hi", ref_hi, 3);
        check("done_busy", busy_cnt, 6);
        check("done_pulses", ref_rises, 1);
        check("done_credit", int'(o_credit), 0);
        check("done_idle_coin_n", int'(o_coin_n), 1);

        // Mode 3: cancel with 2 coins, coin during refund is rejected
        do_reset();
        i_mode_3 = 1'b1;
        insert_coin(1);
        insert_coin(2);
        exp_q.push_back(1);
        exp_q.push_back(0);
        clear_counts();
        i_cancel   = 1'b1;
        i_coin_raw = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (i == 0) i_cancel = 1'b0;
            if (i == 9) i_coin_raw = 1'b0;
        end
        check("cancel_busy", busy_cnt, 12);
        check("cancel_ref_hi", ref_hi, 6);
        check("cancel_pulses", ref_rises, 2);
        check("cancel_reject", rej_seen, 1);
        check("cancel_credit", int'(o_credit), 0);

        // Mode switch from 1 to 3 with credit 2 drops back to collecting
        do_reset();
        i_mode_1 = 1'b1;
        insert_coin(1);
        insert_coin(2);
        check("switch_paid", int'(o_coin_n), 0);
        i_mode_1 = 1'b0;
        i_mode_3 = 1'b1;
        tick();
        check("switch_coin_n_lag", int'(o_coin_n), 0);
        tick();
        check("switch_coin_n", int'(o_coin_n), 1);
        check("switch_price", int'(o_price), 4);

        // Saturation: the 16th coin is rejected and credit holds
        do_reset();
        for (int c = 1; c <= 15; c++) insert_coin(c);
        clear_counts();
        insert_coin(-1);
        check("sat_reject", rej_seen, 1);
        check("sat_credit", int'(o_credit), 15);

        // Reset during the second cycle of a refund pulse
        do_reset();
        i_mode_1 = 1'b1;
        insert_coin(1);
        insert_coin(2);
        i_cancel = 1'b1;
        tick();
        i_cancel = 1'b0;
        check("rstref_pulse", int'(o_refund), 1);
        tick();
        sb_en = 1'b0;
        i_rst = 1'b1;
        tick();
        check("rstref_refund", int'(o_refund), 0);
        check("rstref_credit", int'(o_credit), 0);
        check("rstref_busy", int'(o_refund_busy), 0);
        i_rst = 1'b0;
        sb_en = 1'b1;
        clear_counts();
        ticks(20);
        check("rstref_no_pulses", ref_hi, 0);
        check("rstref_credit_hold", int'(o_credit), 0);

        check("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
